// File: rtl/arc_wordtime_gen.sv
// ARC word-time generator: bit/digit counters, instruction serialiser onto `is`,
// arithmetic field latch and word-select decode, digit pointer register.
module arc_wordtime_gen #(
  parameter int NDIGITS  = 14,
  parameter int DBITS    = 4,
  parameter int ISW      = 10,
  parameter int IS_START = 45,
  parameter int EXP_HI   = 2,
  parameter int MANT_LO  = 3,
  parameter int MANT_HI  = 12,
  parameter int PTR_W    = 4,
  localparam int NBITS   = NDIGITS * DBITS,
  localparam int BCW     = $clog2(NBITS),
  localparam int DCW     = $clog2(NDIGITS)
) (
  input  logic             cph2,
  input  logic             rstn,
  input  logic             run,
  input  logic             inst_valid,
  input  logic [ISW-1:0]   inst_data,
  output logic             inst_ready,
  input  logic [1:0]       ptr_cmd,
  input  logic [PTR_W-1:0] ptr_din,
  output logic [BCW-1:0]   bit_cnt,
  output logic [DCW-1:0]   digit_cnt,
  output logic             word_start,
  output logic             sync,
  output logic             is,
  output logic             ws,
  output logic [PTR_W-1:0] ptr,
  output logic             underrun
);

  localparam int SUBW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [BCW-1:0]   BIT_LAST = BCW'(NBITS - 1);
  localparam logic [BCW-1:0]   LOAD_AT  = BCW'(IS_START - 1);
  localparam logic [BCW-1:0]   SYNC_LO  = BCW'(IS_START);
  localparam logic [BCW-1:0]   SYNC_HI  = BCW'(IS_START + ISW - 1);
  localparam logic [DCW-1:0]   DIG_LAST = DCW'(NDIGITS - 1);
  localparam logic [SUBW-1:0]  SUB_LAST = SUBW'(DBITS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NDIGITS - 1);

  typedef enum logic [2:0] {
    F_P  = 3'b000,
    F_M  = 3'b001,
    F_X  = 3'b010,
    F_W  = 3'b011,
    F_WP = 3'b100,
    F_MS = 3'b101,
    F_XS = 3'b110,
    F_S  = 3'b111
  } field_t;

  logic [SUBW-1:0] sub_cnt;
  logic [ISW-1:0]  hold;
  logic            hold_full;
  logic [ISW-1:0]  shift;
  logic [4:0]      word_lo;
  logic            field_en;
  field_t          field_type;
  logic            load_cyc;
  logic            wrap;

  assign load_cyc   = run && (bit_cnt == LOAD_AT);
  assign wrap       = run && (bit_cnt == BIT_LAST);
  assign inst_ready = ~hold_full;
  assign word_start = (bit_cnt == '0);
  assign sync       = (bit_cnt >= SYNC_LO) && (bit_cnt <= SYNC_HI);
  assign is         = sync & shift[0];
  assign underrun   = load_cyc & ~hold_full;

  // Bit, sub-digit and digit counters; all hold while run is low.
  always_ff @(posedge cph2 or negedge rstn) begin
    if (!rstn) begin
      bit_cnt   <= '0;
      sub_cnt   <= '0;
      digit_cnt <= '0;
    end else if (run) begin
      bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      if (sub_cnt == SUB_LAST) begin
        sub_cnt   <= '0;
        digit_cnt <= (digit_cnt == DIG_LAST) ? '0 : digit_cnt + 1'b1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  // Holding register handshake and shift register load/shift.
  // The load cycle always sees a full or empty holding register before any
  // same-edge handshake, so an accept on that edge waits for the next word.
  always_ff @(posedge cph2 or negedge rstn) begin
    if (!rstn) begin
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      word_lo   <= '0;
    end else begin
      if (load_cyc) begin
        if (hold_full) begin
          shift     <= hold;
          word_lo   <= hold[4:0];
          hold_full <= 1'b0;
        end else begin
          shift   <= '0;
          word_lo <= '0;
        end
      end else if (run && sync) begin
        shift <= shift >> 1;
      end
      if (inst_valid && !hold_full) begin
        hold      <= inst_data;
        hold_full <= 1'b1;
      end
    end
  end

  // Field latch and pointer update, both at the word-wrap edge.
  always_ff @(posedge cph2 or negedge rstn) begin
    if (!rstn) begin
      field_en   <= 1'b0;
      field_type <= F_P;
      ptr        <= '0;
    end else if (wrap) begin
      field_en   <= (word_lo[1:0] == 2'b10);
      field_type <= field_t'(word_lo[4:2]);
      unique case (ptr_cmd)
        2'b01:   ptr <= (ptr_din > PTR_LAST) ? PTR_LAST : ptr_din;
        2'b10:   ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        2'b11:   ptr <= (ptr == '0) ? PTR_LAST : ptr - 1'b1;
        default: ptr <= ptr;
      endcase
    end
  end

  logic [31:0] d_ext;
  logic [31:0] p_ext;

  // Word-select decode from the latched field and current digit.
  always_comb begin
    d_ext = 32'(digit_cnt);
    p_ext = 32'(ptr);
    ws    = 1'b1;
    if (field_en) begin
      unique case (field_type)
        F_P:     ws = (d_ext == p_ext);
        F_M:     ws = (d_ext >= 32'(MANT_LO)) && (d_ext <= 32'(MANT_HI));
        F_X:     ws = (d_ext <= 32'(EXP_HI));
        F_W:     ws = 1'b1;
        F_WP:    ws = (d_ext <= p_ext);
        F_MS:    ws = (d_ext >= 32'(MANT_LO));
        F_XS:    ws = (d_ext == 32'(EXP_HI));
        F_S:     ws = (d_ext == 32'(NDIGITS - 1));
        default: ws = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_arc_wordtime_gen.sv
// Bench for arc_wordtime_gen: behavioural word-position model, randomized and
// directed scenarios, one task per scenario.
module tb_arc_wordtime_gen;

  logic       cph2 = 1'b0;
  logic       rstn;
  logic       run;
  logic       inst_valid;
  logic [9:0] inst_data;
  logic       inst_ready;
  logic [1:0] ptr_cmd;
  logic [3:0] ptr_din;
  logic [5:0] bit_cnt;
  logic [3:0] digit_cnt;
  logic       word_start;
  logic       sync;
  logic       is;
  logic       ws;
  logic [3:0] ptr;
  logic       underrun;

  arc_wordtime_gen #(
    .NDIGITS (14),
    .DBITS   (4),
    .ISW     (10),
    .IS_START(45),
    .EXP_HI  (2),
    .MANT_LO (3),
    .MANT_HI (12),
    .PTR_W   (4)
  ) dut (
    .cph2      (cph2),
    .rstn      (rstn),
    .run       (run),
    .inst_valid(inst_valid),
    .inst_data (inst_data),
    .inst_ready(inst_ready),
    .ptr_cmd   (ptr_cmd),
    .ptr_din   (ptr_din),
    .bit_cnt   (bit_cnt),
    .digit_cnt (digit_cnt),
    .word_start(word_start),
    .sync      (sync),
    .is        (is),
    .ws        (ws),
    .ptr       (ptr),
    .underrun  (underrun)
  );

  always #5 cph2 = ~cph2;

  logic [19:0] obs;
  assign obs = {bit_cnt, digit_cnt, word_start, sync, is, ws, ptr, underrun, inst_ready};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position within the word, pending word, word on the wire.
  int m_pos;
  bit m_full;
  int m_hold;
  int m_word;
  bit m_fen;
  int m_ftype;
  int m_ptr;

  task automatic model_reset();
    m_pos = 0; m_full = 0; m_hold = 0; m_word = 0;
    m_fen = 0; m_ftype = 0; m_ptr = 0;
  endtask

  function automatic bit ws_ref(int d);
    if (!m_fen) return 1'b1;
    case (m_ftype)
      0: return d == m_ptr;
      1: return d >= 3 && d <= 12;
      2: return d <= 2;
      3: return 1'b1;
      4: return d <= m_ptr;
      5: return d >= 3;
      6: return d == 2;
      default: return d == 13;
    endcase
  endfunction

  function automatic logic [19:0] exp_vec();
    int d;
    bit sy;
    bit isb;
    bit und;
    d   = m_pos / 4;
    sy  = (m_pos >= 45) && (m_pos <= 54);
    isb = sy ? bit'((m_word >> (m_pos - 45)) & 1) : 1'b0;
    und = run && (m_pos == 44) && !m_full;
    return {6'(m_pos), 4'(d), m_pos == 0, sy, isb, ws_ref(d), 4'(m_ptr), und, !m_full};
  endfunction

  // Advance one clock and apply the word-level rules to the model.
  task automatic tick();
    bit load;
    bit wrap;
    bit hs;
    @(posedge cph2);
    load = run && (m_pos == 44);
    wrap = run && (m_pos == 55);
    hs   = inst_valid && !m_full;
    if (load) begin
      if (m_full) begin m_word = m_hold; m_full = 0; end
      else m_word = 0;
    end
    if (hs) begin m_hold = int'(inst_data); m_full = 1; end
    if (wrap) begin
      m_fen   = (m_word % 4) == 2;
      m_ftype = (m_word / 4) % 8;
      case (ptr_cmd)
        2'b01: m_ptr = (int'(ptr_din) > 13) ? 13 : int'(ptr_din);
        2'b10: m_ptr = (m_ptr + 1) % 14;
        2'b11: m_ptr = (m_ptr + 13) % 14;
        default: ;
      endcase
    end
    if (run) m_pos = (m_pos + 1) % 56;
    @(negedge cph2);
  endtask

  task automatic test_reset();
    rstn = 1'b0; run = 1'b0; inst_valid = 1'b0; inst_data = '0;
    ptr_cmd = 2'b00; ptr_din = '0;
    model_reset();
    @(negedge cph2);
    @(negedge cph2);
    #1;
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_bad++; $display("FAIL reset_state got=%h exp=%h", obs, exp_vec());
    end
    n_cmp++;
    if ({ws, inst_ready, is, underrun, bit_cnt} !== {1'b1, 1'b1, 1'b0, 1'b0, 6'd0}) begin
      n_bad++; $display("FAIL reset_consts got ws=%b rdy=%b is=%b und=%b bit=%0d", ws, inst_ready, is, underrun, bit_cnt);
    end
    @(negedge cph2);
    rstn = 1'b1;
  endtask

  task automatic test_idle();
    int n_und = 0;
    run = 1'b1; inst_valid = 1'b0;
    for (int i = 0; i < 112; i++) begin
      #1;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL idle pos=%0d got=%h exp=%h", m_pos, obs, exp_vec());
      end
      if (underrun) n_und++;
      tick();
    end
    n_cmp++;
    if (n_und !== 2) begin n_bad++; $display("FAIL idle_underrun_count got=%0d exp=2", n_und); end
  endtask

  task automatic test_field_m();
    logic [9:0] isv = '0;
    logic [9:0] exp_is = 10'b11111_001_10;
    int n_ws = 0;
    run = 1'b1;
    for (int i = 0; i < 168; i++) begin
      inst_valid = (i == 0);
      inst_data  = 10'b11111_001_10;
      #1;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL field_m pos=%0d got=%h exp=%h", m_pos, obs, exp_vec());
      end
      if (i < 56 && m_pos >= 45 && m_pos <= 54) isv[m_pos - 45] = is;
      if (i >= 56 && i < 112 && ws) n_ws++;
      tick();
    end
    inst_valid = 1'b0;
    n_cmp++;
    if (isv !== exp_is) begin n_bad++; $display("FAIL is_sequence got=%b exp=%b", isv, exp_is); end
    n_cmp++;
    if (n_ws !== 40) begin n_bad++; $display("FAIL ws_m_count got=%0d exp=40", n_ws); end
  endtask

  task automatic test_pointer();
    int ws_cnt[8];
    int exp_ptr[8] = '{0, 3, 3, 3, 13, 0, 13, 13};
    logic [1:0] cmd_tab[8] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
    logic [3:0] din_tab[8] = '{4'd3, 4'd0, 4'd0, 4'd13, 4'd0, 4'd0, 4'd15, 4'd0};
    run = 1'b1;
    for (int w = 0; w < 8; w++) ws_cnt[w] = 0;
    for (int i = 0; i < 8 * 56; i++) begin
      int w;
      w = i / 56;
      ptr_cmd    = cmd_tab[w];
      ptr_din    = din_tab[w];
      inst_valid = (i == 0) || (i == 56);
      inst_data  = (i == 0) ? 10'b00000_000_10 : 10'b00000_100_10;
      #1;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL pointer pos=%0d got=%h exp=%h", m_pos, obs, exp_vec());
      end
      if (i % 56 == 0) begin
        n_cmp++;
        if (ptr !== 4'(exp_ptr[w])) begin
          n_bad++; $display("FAIL ptr_word%0d got=%0d exp=%0d", w, ptr, exp_ptr[w]);
        end
      end
      if (ws) ws_cnt[w]++;
      tick();
    end
    inst_valid = 1'b0; ptr_cmd = 2'b00;
    n_cmp++;
    if (ws_cnt[1] !== 4) begin n_bad++; $display("FAIL ws_p_count got=%0d exp=4", ws_cnt[1]); end
    n_cmp++;
    if (ws_cnt[2] !== 16) begin n_bad++; $display("FAIL ws_wp_count got=%0d exp=16", ws_cnt[2]); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] q[$];
    int n_und = 0;
    run = 1'b1; ptr_cmd = 2'b00;
    q.push_back({5'($urandom), 3'($urandom), 2'b10});
    q.push_back({5'($urandom), 3'($urandom), 2'b10});
    for (int i = 0; i < 112; i++) begin
      bit hs;
      inst_valid = (q.size() > 0);
      inst_data  = (q.size() > 0) ? q[0] : 10'($urandom);
      #1;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL b2b pos=%0d got=%h exp=%h", m_pos, obs, exp_vec());
      end
      if (i == 30) begin
        n_cmp++;
        if (inst_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_held got=%b exp=0", inst_ready); end
      end
      if (underrun) n_und++;
      hs = inst_valid && !m_full;
      tick();
      if (hs) void'(q.pop_front());
    end
    inst_valid = 1'b0;
    n_cmp++;
    if (n_und !== 0) begin n_bad++; $display("FAIL b2b_underrun got=%0d exp=0", n_und); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      run        = ($urandom_range(0, 9) != 0);
      inst_valid = ($urandom_range(0, 3) == 0);
      inst_data  = 10'($urandom);
      ptr_cmd    = 2'($urandom);
      ptr_din    = 4'($urandom);
      #1;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL random pos=%0d got=%h exp=%h", m_pos, obs, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_freeze_reset();
    logic [9:0] wv;
    int n_is = 0;
    run = 1'b1; inst_valid = 1'b0; ptr_cmd = 2'b01; ptr_din = 4'd5;
    for (int i = 0; i < 120; i++) begin
      #1;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL frz_align pos=%0d got=%h exp=%h", m_pos, obs, exp_vec());
      end
      tick();
      if (m_pos == 0 && i > 0) break;
    end
    ptr_cmd = 2'b00;
    n_cmp++;
    if (ptr !== 4'd5 || bit_cnt !== 6'd0) begin
      n_bad++; $display("FAIL frz_start got ptr=%0d bit=%0d exp ptr=5 bit=0", ptr, bit_cnt);
    end
    wv = {5'($urandom), 5'b10110};
    for (int i = 0; i < 60 && m_pos != 47; i++) begin
      inst_valid = (i == 0); inst_data = wv;
      #1;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL frz_pre pos=%0d got=%h exp=%h", m_pos, obs, exp_vec());
      end
      tick();
    end
    inst_valid = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (obs !== exp_vec() || bit_cnt !== 6'd47 || is !== wv[2]) begin
        n_bad++; $display("FAIL frozen got=%h exp=%h is=%b exp_is=%b", obs, exp_vec(), is, wv[2]);
      end
      tick();
    end
    run = 1'b1;
    for (int i = 0; i < 10 && m_pos != 50; i++) begin
      inst_valid = (m_pos == 48); inst_data = 10'($urandom);
      #1;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL frz_post pos=%0d got=%h exp=%h", m_pos, obs, exp_vec());
      end
      tick();
    end
    inst_valid = 1'b0;
    rstn = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({is, ws, ptr, bit_cnt, inst_ready} !== {1'b0, 1'b1, 4'd0, 6'd0, 1'b1}) begin
      n_bad++; $display("FAIL midword_reset got is=%b ws=%b ptr=%0d bit=%0d rdy=%b", is, ws, ptr, bit_cnt, inst_ready);
    end
    @(negedge cph2);
    rstn = 1'b1;
    for (int i = 0; i < 56; i++) begin
      #1;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL after_reset pos=%0d got=%h exp=%h", m_pos, obs, exp_vec());
      end
      if (is) n_is++;
      tick();
    end
    n_cmp++;
    if (n_is !== 0) begin n_bad++; $display("FAIL partial_emission got=%0d exp=0", n_is); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_field_m();
    test_pointer();
    test_back_to_back();
    test_random();
    test_freeze_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
